// File: rtl/alu_seq.sv
// Handshaked sequential ALU with a persistent carry flag, barrel shifts and an optional
// iterative shift-add multiplier (enabled by defining ALU_SEQ_MUL_EN).
module alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [3:0]       select,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic             zero
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] alu_out_q;
  logic             carry_q;
  logic             zero_q;

  logic             accept;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res;
  logic             res_cy;
  logic             res_zf;
  logic             is_cmp;

  assign in_ready = !rst && (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Only ADC/SBB consume the stored carry.
  assign cin   = (select[3:1] == 3'b001) && carry_q;
  assign sum   = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, cin};
  assign diff  = {1'b0, in_a} - {1'b0, in_b} - {{WIDTH{1'b0}}, cin};
  assign shamt = in_b[SHW-1:0];
  assign is_cmp = !mode && (select == 4'b0110);

  always_comb begin
    res    = '0;
    res_cy = 1'b0;
    if (!mode) begin
      case (select)
        4'b0000, 4'b0010: {res_cy, res} = sum;
        4'b0001, 4'b0011: {res_cy, res} = diff;
        4'b0110: begin
          res    = in_a;
          res_cy = diff[WIDTH];
        end
        default: ;
      endcase
    end else begin
      case (select)
        4'b0000: res = in_a & in_b;
        4'b0001: res = in_a | in_b;
        4'b0010: res = in_a ^ in_b;
        4'b0011: res = ~in_a;
        4'b0100: res = ~in_b;
        4'b0101: res = in_a;
        4'b0110: res = in_b;
        4'b1001: res = in_a << shamt;
        4'b1010: res = in_a >> shamt;
        4'b1011: res = $signed(in_a) >>> shamt;
        default: ;
      endcase
    end
    res_zf = is_cmp ? (diff[WIDTH-1:0] == '0) : (res == '0);
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int unsigned CW = SHW + 1;

  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   mul_a_q;
  logic [2*WIDTH-1:0] mul_acc_q;
  logic               mul_high_q;
  logic               is_mul;
  logic [WIDTH:0]     mul_hi_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   mul_res;

  assign is_mul = !mode && (select[3:1] == 3'b010);

  // Accumulator low half starts as the multiplier and shifts out one bit per step.
  assign mul_hi_sum = {1'b0, mul_acc_q[2*WIDTH-1:WIDTH]} +
                      (mul_acc_q[0] ? {1'b0, mul_a_q} : {(WIDTH+1){1'b0}});
  assign mul_next   = {mul_hi_sum, mul_acc_q[WIDTH-1:1]};
  assign mul_res    = mul_high_q ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_acc_q   <= '0;
      mul_high_q  <= 1'b0;
`endif
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
`ifdef ALU_SEQ_MUL_EN
        if (is_mul) begin
          mul_a_q    <= in_a;
          mul_acc_q  <= {{WIDTH{1'b0}}, in_b};
          mul_high_q <= select[0];
          cnt_q      <= CW'(WIDTH);
          state_q    <= StMul;
        end else
`endif
        begin
          alu_out_q   <= res;
          carry_q     <= res_cy;
          zero_q      <= res_zf;
          out_valid_q <= 1'b1;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      if (state_q == StMul) begin
        cnt_q     <= cnt_q - 1'b1;
        mul_acc_q <= mul_next;
        if (cnt_q == CW'(1)) begin
          alu_out_q   <= mul_res;
          carry_q     <= 1'b0;
          zero_q      <= (mul_res == '0);
          out_valid_q <= 1'b1;
          state_q     <= StIdle;
        end
      end
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign alu_out   = alu_out_q;
  assign carry_out = carry_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=16); multiplier checks follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic [3:0]  select;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] alu_out;
  logic        carry_out;
  logic        zero;

  int n_checks = 0;
  int n_pass   = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .select    (select),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .carry_out (carry_out),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Waits (bounded) for in_ready, presents one request for one accept edge, returns #1 after it.
  task automatic issue(input logic m, input logic [3:0] s, input logic [15:0] a,
                       input logic [15:0] b);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check_eq("issue_timeout", 0, 1);
    mode     = m;
    select   = s;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic [15:0] v, input logic c,
                            input logic z);
    check_eq({tag, ".valid"}, out_valid, 1);
    check_eq({tag, ".out"}, alu_out, v);
    check_eq({tag, ".carry"}, carry_out, c);
    check_eq({tag, ".zero"}, zero, z);
  endtask

  initial begin
    int  cycles;
    bit  seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    mode      = 1'b0;
    select    = 4'h0;
    in_a      = 16'h0;
    in_b      = 16'h0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.in_ready", in_ready, 0);
    check_eq("rst.out_valid", out_valid, 0);
    check_eq("rst.alu_out", alu_out, 0);
    check_eq("rst.carry", carry_out, 0);
    check_eq("rst.zero", zero, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rel.in_ready", in_ready, 1);

    // Carry chaining
    issue(1'b0, 4'b0000, 16'hFFFF, 16'h0001);
    expect_res("add", 16'h0000, 1'b1, 1'b1);
    issue(1'b0, 4'b0010, 16'h0000, 16'h0000);
    expect_res("adc", 16'h0001, 1'b0, 1'b0);
    issue(1'b0, 4'b0001, 16'h0003, 16'h0005);
    expect_res("sub", 16'hFFFE, 1'b1, 1'b0);
    issue(1'b0, 4'b0110, 16'h1234, 16'h1234);
    expect_res("cmp", 16'h1234, 1'b0, 1'b1);
    issue(1'b0, 4'b0001, 16'h0000, 16'h0001);
    expect_res("sub2", 16'hFFFF, 1'b1, 1'b0);
    issue(1'b0, 4'b0011, 16'h0005, 16'h0002);
    expect_res("sbb", 16'h0002, 1'b0, 1'b0);
    // Non-arithmetic ops clear C
    issue(1'b0, 4'b0000, 16'hFFFF, 16'h0001);
    issue(1'b1, 4'b0001, 16'h0000, 16'h0000);
    expect_res("or0", 16'h0000, 1'b0, 1'b1);
    issue(1'b0, 4'b0010, 16'h0001, 16'h0001);
    expect_res("adc_noc", 16'h0002, 1'b0, 1'b0);

    issue(1'b1, 4'b0000, 16'hF0F0, 16'hFF00);
    expect_res("and", 16'hF000, 1'b0, 1'b0);
    issue(1'b1, 4'b0010, 16'hAAAA, 16'hAAAA);
    expect_res("xor", 16'h0000, 1'b0, 1'b1);
    issue(1'b1, 4'b0011, 16'h00FF, 16'h1111);
    expect_res("nota", 16'hFF00, 1'b0, 1'b0);
    issue(1'b1, 4'b0110, 16'h5555, 16'h1234);
    expect_res("passb", 16'h1234, 1'b0, 1'b0);
    issue(1'b1, 4'b0111, 16'hFFFF, 16'hFFFF);
    expect_res("m1_undef", 16'h0000, 1'b0, 1'b1);
    issue(1'b0, 4'b0111, 16'hFFFF, 16'h0001);
    expect_res("m0_undef", 16'h0000, 1'b0, 1'b1);

    issue(1'b1, 4'b1001, 16'h0001, 16'h0013);
    expect_res("shl", 16'h0008, 1'b0, 1'b0);
    issue(1'b1, 4'b1011, 16'h8000, 16'h0004);
    expect_res("sar", 16'hF800, 1'b0, 1'b0);
    issue(1'b1, 4'b1010, 16'h8000, 16'h0004);
    expect_res("shr", 16'h0800, 1'b0, 1'b0);
    issue(1'b1, 4'b1001, 16'h1234, 16'h0010);
    expect_res("shl0", 16'h1234, 1'b0, 1'b0);

    // Back-pressure: outputs hold, ignored request while stalled
    issue(1'b1, 4'b0000, 16'hFFFF, 16'h00FF);
    out_ready = 1'b0;
    mode      = 1'b1;
    select    = 4'b0001;
    in_a      = 16'hFFFF;
    in_b      = 16'h0000;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("stall.valid", out_valid, 1);
      check_eq("stall.out", alu_out, 16'h00FF);
      check_eq("stall.in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("drain.valid", out_valid, 0);
    check_eq("drain.out", alu_out, 16'h00FF);

`ifdef ALU_SEQ_MUL_EN
    issue(1'b0, 4'b0100, 16'h0123, 16'h0456);
    cycles = 0;
    seen   = 1'b0;
    while (!out_valid && cycles < 40) begin
      if (in_ready) seen = 1'b1;
      @(posedge clk);
      #1;
      cycles++;
    end
    check_eq("mul.latency", cycles, 16);
    check_eq("mul.ready_low", seen, 0);
    expect_res("mul", 16'hEDC2, 1'b0, 1'b0);
    issue(1'b0, 4'b0101, 16'h0123, 16'h0456);
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check_eq("mulh.latency", cycles, 16);
    expect_res("mulh", 16'h0004, 1'b0, 1'b0);
`else
    issue(1'b0, 4'b0100, 16'h0123, 16'h0456);
    expect_res("mul_off", 16'h0000, 1'b0, 1'b1);
    issue(1'b0, 4'b0101, 16'h0123, 16'h0456);
    expect_res("mulh_off", 16'h0000, 1'b0, 1'b1);
`endif

    // Reset during a multiply
    issue(1'b0, 4'b0000, 16'hFFFF, 16'h0001);
    check_eq("pre_rst.carry", carry_out, 1);
    issue(1'b0, 4'b0100, 16'h0123, 16'h0456);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mrst.valid", out_valid, 0);
    check_eq("mrst.in_ready", in_ready, 0);
    check_eq("mrst.carry", carry_out, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("mrst.rel_ready", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check_eq("mrst.no_result", seen, 0);
    issue(1'b0, 4'b0010, 16'h0000, 16'h0000);
    expect_res("mrst.adc", 16'h0000, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor of the datapath ALU. Executes arithmetic and logic operations on WIDTH-bit operands and holds a carry flag across operations, so ADC/SBB chain multi-word arithmetic without external carry plumbing. Adds barrel shifts and an iterative shift-add multiplier. It sits between the register-file read stage and writeback, behind a valid/ready interface on both sides.

## Interface
- WIDTH, 16, operand/result width; power of two, ≥4. Shift amount width SHW = $clog2(WIDTH).
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- mode  in  1  0 = arithmetic, 1 = logic/shift
- select  in  4  operation code
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B; low SHW bits are the shift amount for shifts
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  downstream consumes the result
- alu_out  out  WIDTH  result
- carry_out  out  1  carry/borrow flag of this result (equals internal carry flag)
- zero  out  1  flag-source value == 0

## Operation
- Mode 0: 0000 ADD a+b; 0001 SUB a−b; 0010 ADC a+b+C; 0011 SBB a−b−C; 0100 MUL low WIDTH bits of unsigned a×b; 0101 MULH high WIDTH bits; 0110 CMP (flags from a−b, alu_out = a); others → 0.
- Mode 1: 0000 AND; 0001 OR; 0010 XOR; 0011 ~a; 0100 ~b; 0101 pass a; 0110 pass b; 1001 SHL a by b[SHW-1:0]; 1010 SHR logical; 1011 SAR arithmetic; others (incl. 0111, 1000) → 0.
- Arithmetic is computed at WIDTH+1 bits unsigned; carry = bit WIDTH. On subtract this bit is borrow (1 when a < b + C).
- C is the internal carry flag. It is written whenever a result is produced: ADD/SUB/ADC/SBB/CMP write bit WIDTH; all other ops write 0.
- zero = (a−b == 0) for CMP; (alu_out == 0) otherwise.
- State machine: IDLE, MUL.
  - IDLE: accepts a request on in_valid && in_ready.
  - Single-cycle op: result, flags and out_valid are written at the accept edge.
  - MUL/MULH: operands are latched, the counter is loaded with WIDTH, and the state goes to MUL.
  - MUL: one multiplier bit per cycle into a 2·WIDTH accumulator. When the counter expires, the selected half is written, out_valid is set and the state returns to IDLE.
- in_ready = !rst && state == IDLE && (!out_valid || out_ready). A same-cycle drain-and-accept is permitted.
- Output hold: while out_valid && !out_ready, alu_out, carry_out and zero are stable. out_valid clears on out_ready unless a new result is written the same edge.
- ADC/SBB accepted in the cycle after a flag-writing op use the updated C, so back-to-back chaining works.

## Timing
- Reset values: out_valid 0, alu_out 0, carry_out 0, zero 0, C 0, state IDLE, counter 0. in_ready is 0 while rst is high and 1 on the first cycle after release.
- Latency: single-cycle ops 1 cycle (accept edge k → out_valid high after edge k). MUL/MULH take WIDTH cycles (out_valid high after edge k+WIDTH). in_ready is low for those WIDTH cycles.
- Throughput: 1 op/cycle for single-cycle ops with out_ready held high.
- Reset mid-MUL aborts the operation. No result is produced and C is cleared.
- Shift amount 0 returns a unchanged. SAR fills with a[WIDTH-1].
- in_valid without in_ready has no effect. Inputs are sampled only on the accept edge.

## Configuration
- ALU_SEQ_MUL_EN defined: MUL/MULH are implemented as above, with the MUL state, counter and accumulator.
- ALU_SEQ_MUL_EN undefined: no multiplier hardware. Mode 0 selects 0100/0101 behave as undefined selects: single-cycle, alu_out 0, carry 0, zero 1.

## Test plan
- ADD 0xFFFF+0x0001 → one cycle later alu_out 0x0000, carry_out 1, zero 1.
- ADD 0xFFFF+0x0001 then back-to-back ADC 0x0000+0x0000 → second result 0x0001, carry_out 0, zero 0.
- SUB 0x0003−0x0005 → 0xFFFE, carry 1. CMP 0x1234,0x1234 → alu_out 0x1234, zero 1, carry 0.
- MUL 0x0123×0x0456 → 0xEDC2 exactly 16 cycles after accept, in_ready low throughout; MULH with the same operands → 0x0004. Without the macro, the MUL select → 0x0000 after 1 cycle.
- SHL 0x0001 by in_b=0x0013 → 0x0008. SAR 0x8000 by 4 → 0xF800. out_ready held low 3 cycles → outputs stable and in_ready 0 until drain.
- rst asserted in cycle 5 of a MUL → out_valid stays 0, C = 0, in_ready 1 one cycle after release.
